mem_port_arbiter: RTL

- Parametrised N-channel arbiter for one shared external memory port (ARAM, ROM or cart RAM style: ce_n/oe_n/we_n strobes).
- Replaces fixed combinational source muxing (savestate-over-SNES style) with registered, handshaked, single-beat access scheduling.
- Supports fixed-priority or round-robin selection.
- Sits between the core and its requestors (CPU/APU path, savestate engine, expansion logic) and the memory pins.

---
 rtl/sgb_mem_pkg.sv | 31 +++
 rtl/mem_port_arbiter_arb_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/sgb_mem_pkg.sv
// Shared types, width helpers and parameter legality checks for the
// memory-port arbitration logic.
package sgb_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam int unsigned MAX_NCH    = 8;
    localparam int unsigned MAX_RD_LAT = 8;

    // Width of a channel index / round-robin pointer for n channels.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a down-counter that must hold lat-1.
    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

    function automatic bit nch_legal(input int unsigned n);
        return (n >= 1) && (n <= MAX_NCH);
    endfunction

    function automatic bit rd_lat_legal(input int unsigned lat);
        return (lat >= 1) && (lat <= MAX_RD_LAT);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection: fixed priority (lowest index) or
// round-robin starting at ptr_i, wrapping modulo N.
module arb_pick #(
    parameter int unsigned N = 3,
    parameter int unsigned W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    input  logic         rr_i,
    output logic [N-1:0] onehot_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    always_comb begin
        int unsigned c;
        logic [W-1:0] cw;
        any_o    = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        c        = 0;
        cw       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            c  = rr_i ? ((32'(ptr_i) + k) % N) : k;
            cw = W'(c);
            if (!any_o && req_i[cw]) begin
                any_o        = 1'b1;
                idx_o        = cw;
                onehot_o[cw] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Registered single-beat arbiter for one shared ce_n/oe_n/we_n memory port.
// Arbitrates only in IDLE; each access holds the port until it completes.
module mem_port_arbiter
    import sgb_mem_pkg::*;
#(
    parameter int unsigned NCH    = 3,
    parameter int unsigned AW     = 24,
    parameter int unsigned DW     = 16,
    parameter int unsigned RR     = 0,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req,
    input  logic [NCH-1:0]    we,
    input  logic [NCH*AW-1:0] addr,
    input  logic [NCH*DW-1:0] wdata,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    rvalid,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_d,
    input  logic [DW-1:0]     mem_q,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
);

    localparam int unsigned PW = idx_width(NCH);
    localparam int unsigned CW = cnt_width(RD_LAT);

    if (!nch_legal(NCH)) begin : g_bad_nch
        $error("mem_port_arbiter: NCH must be in 1..8");
    end
    if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
        $error("mem_port_arbiter: RD_LAT must be in 1..8");
    end

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   owner_q;
    logic [CW-1:0]   cnt_q;
    logic [NCH-1:0]  gnt_q;
    logic [NCH-1:0]  rvalid_q;
    logic [DW-1:0]   rdata_q;
    logic            busy_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_d_q;
    logic            mem_ce_n_q;
    logic            mem_oe_n_q;
    logic            mem_we_n_q;

    logic [NCH-1:0]  pick_oh;
    logic [PW-1:0]   pick_idx;
    logic            pick_any;
    logic [PW-1:0]   ptr_d;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic            sel_we;

    arb_pick #(
        .N (NCH),
        .W (PW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .rr_i     (RR != 0),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (pick_idx == PW'(i)) begin
                sel_addr  = addr[i*AW +: AW];
                sel_wdata = wdata[i*DW +: DW];
                sel_we    = we[i];
            end
        end
        ptr_d = (pick_idx == PW'(NCH - 1)) ? '0 : pick_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            busy_q     <= 1'b0;
            mem_addr_q <= '0;
            mem_d_q    <= '0;
            mem_ce_n_q <= 1'b1;
            mem_oe_n_q <= 1'b1;
            mem_we_n_q <= 1'b1;
        end else begin
            gnt_q    <= '0;
            rvalid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q    <= ACCESS;
                        gnt_q      <= pick_oh;
                        busy_q     <= 1'b1;
                        mem_addr_q <= sel_addr;
                        mem_d_q    <= sel_wdata;
                        mem_ce_n_q <= 1'b0;
                        owner_q    <= pick_idx;
                        ptr_q      <= ptr_d;
                        if (sel_we) begin
                            mem_we_n_q <= 1'b0;
                            cnt_q      <= '0;
                        end else begin
                            mem_oe_n_q <= 1'b0;
                            cnt_q      <= CW'(RD_LAT - 1);
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // oe_n still low here identifies the access as a read
                        if (!mem_oe_n_q) begin
                            rdata_q  <= mem_q;
                            rvalid_q <= NCH'(1) << owner_q;
                        end
                        mem_ce_n_q <= 1'b1;
                        mem_oe_n_q <= 1'b1;
                        mem_we_n_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign busy     = busy_q;
    assign mem_addr = mem_addr_q;
    assign mem_d    = mem_d_q;
    assign mem_ce_n = mem_ce_n_q;
    assign mem_oe_n = mem_oe_n_q;
    assign mem_we_n = mem_we_n_q;

endmodule
